// File: rtl/roll_pkg.sv
// Shared types and defaults for the roll-mode decimator.
package roll_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int NCH_DEF    = 2;

   typedef enum logic [1:0] {
      ROLL_SAMPLE = 2'd0,
      ROLL_MAX    = 2'd1,
      ROLL_MIN    = 2'd2,
      ROLL_MINMAX = 2'd3
   } roll_mode_e;

   typedef enum logic {
      ST_ACC      = 1'b0,
      ST_EMIT_MAX = 1'b1
   } roll_state_e;

endpackage

// File: rtl/roll_ch_acc.sv
// One channel of the decimator: last sample plus running max/min.
module roll_ch_acc
   import roll_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              first,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] last_nxt,
   output logic [DATA_W-1:0] mx_nxt,
   output logic [DATA_W-1:0] mn_nxt
);

   logic [DATA_W-1:0] last_q;
   logic [DATA_W-1:0] mx_q;
   logic [DATA_W-1:0] mn_q;

   // Next-state values include the sample accepted this cycle.
   always_comb begin
      last_nxt = last_q;
      mx_nxt   = mx_q;
      mn_nxt   = mn_q;
      if (en) begin
         last_nxt = d;
         if (first) begin
            mx_nxt = d;
            mn_nxt = d;
         end else begin
            if (d > mx_q) mx_nxt = d;
            if (d < mn_q) mn_nxt = d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= '0;
         mx_q   <= '0;
         mn_q   <= '0;
      end else begin
         last_q <= last_nxt;
         mx_q   <= mx_nxt;
         mn_q   <= mn_nxt;
      end
   end

endmodule

// File: rtl/roll_decimator.sv
// Multi-channel roll-mode decimator: window counter, latched config,
// emit FSM and registered display write port.
module roll_decimator
   import roll_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int NCH     = NCH_DEF,
   parameter int PRESC_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [NCH*DATA_W-1:0] in_data,
   input  logic [PRESC_W-1:0]    prescaler,
   input  logic [1:0]            mode,
   output logic [NCH*DATA_W-1:0] out_data,
   output logic                  w_clk,
   output logic                  out_tag
);

   localparam int W = NCH * DATA_W;
   localparam logic [PRESC_W-1:0] ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

   logic [PRESC_W-1:0] cnt;
   logic [PRESC_W-1:0] presc_l;
   logic [PRESC_W-1:0] presc_c;
   logic [PRESC_W-1:0] last_idx;
   roll_mode_e         mode_l;
   roll_mode_e         mode_c;
   roll_state_e        state;
   logic               first;
   logic               done;
   logic [W-1:0]       last_w;
   logic [W-1:0]       mx_w;
   logic [W-1:0]       mn_w;
   logic [W-1:0]       prim;
   logic [W-1:0]       mx_hold;
   logic [W-1:0]       pend_data;
   logic               pend_v;

   // At the first sample the live inputs define the window.
   assign first    = (cnt == '0);
   assign presc_c  = first ? prescaler : presc_l;
   assign mode_c   = first ? roll_mode_e'(mode) : mode_l;
   assign last_idx = (mode_c == ROLL_MINMAX && presc_c == '0)
                     ? ONE : presc_c;
   assign done     = in_valid && (cnt == last_idx);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      roll_ch_acc #(.DATA_W(DATA_W)) u_acc (
         .clk      (clk),
         .rst      (rst),
         .en       (in_valid),
         .first    (first),
         .d        (in_data[c*DATA_W +: DATA_W]),
         .last_nxt (last_w[c*DATA_W +: DATA_W]),
         .mx_nxt   (mx_w[c*DATA_W +: DATA_W]),
         .mn_nxt   (mn_w[c*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      prim = mn_w;
      unique case (mode_c)
         ROLL_SAMPLE: prim = last_w;
         ROLL_MAX:    prim = mx_w;
         ROLL_MIN:    prim = mn_w;
         ROLL_MINMAX: prim = mn_w;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         presc_l   <= '0;
         mode_l    <= ROLL_SAMPLE;
         state     <= ST_ACC;
         out_data  <= '0;
         w_clk     <= 1'b0;
         out_tag   <= 1'b0;
         mx_hold   <= '0;
         pend_data <= '0;
         pend_v    <= 1'b0;
      end else begin
         w_clk   <= 1'b0;
         out_tag <= 1'b0;
         if (in_valid) begin
            cnt <= done ? '0 : cnt + ONE;
            if (first) begin
               presc_l <= prescaler;
               mode_l  <= roll_mode_e'(mode);
            end
         end
         unique case (state)
            ST_ACC: begin
               // A one-sample window finishing during EMIT_MAX slips a cycle.
               if (pend_v) begin
                  w_clk     <= 1'b1;
                  out_data  <= pend_data;
                  pend_v    <= done;
                  pend_data <= prim;
               end else if (done) begin
                  w_clk    <= 1'b1;
                  out_data <= prim;
                  if (mode_c == ROLL_MINMAX) begin
                     mx_hold <= mx_w;
                     state   <= ST_EMIT_MAX;
                  end
               end
            end
            ST_EMIT_MAX: begin
               w_clk     <= 1'b1;
               out_tag   <= 1'b1;
               out_data  <= mx_hold;
               pend_v    <= done;
               pend_data <= prim;
               state     <= ST_ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_roll_decimator.sv
// Directed and random checks of roll_decimator against a window model.
module tb_roll_decimator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] in_data;
   logic [15:0] prescaler;
   logic [1:0]  mode;
   logic [23:0] out_data;
   logic        w_clk;
   logic        out_tag;

   int n_assert = 0;
   int n_fail   = 0;

   int m0[$];
   int m1[$];
   int m_len;
   int m_mode;
   bit nxt_v;
   logic [23:0] nxt_d;
   bit          exp_w;
   logic [23:0] exp_d;
   bit          exp_t;
   logic [24:0] obs[$];

   roll_decimator #(.DATA_W(12), .NCH(2), .PRESC_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .prescaler (prescaler),
      .mode      (mode),
      .out_data  (out_data),
      .w_clk     (w_clk),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // sel: 0 last, 1 max, 2 min
   function automatic int pick(input int q[$], input int sel);
      int r = q[0];
      foreach (q[i]) begin
         if (sel == 0) r = q[i];
         else if (sel == 1 && q[i] > r) r = q[i];
         else if (sel == 2 && q[i] < r) r = q[i];
      end
      return r;
   endfunction

   function automatic logic [23:0] pack2(input int a, input int b);
      logic [11:0] lo = a[11:0];
      logic [11:0] hi = b[11:0];
      return {hi, lo};
   endfunction

   task automatic model(input bit r, input bit v, input int d0,
                        input int d1, input int presc, input int md);
      exp_w = 1'b0;
      exp_t = 1'b0;
      if (r) begin
         m0.delete();
         m1.delete();
         nxt_v = 1'b0;
         return;
      end
      if (nxt_v) begin
         exp_w = 1'b1;
         exp_d = nxt_d;
         exp_t = 1'b1;
         nxt_v = 1'b0;
      end
      if (v) begin
         if (m0.size() == 0) begin
            m_mode = md;
            m_len  = presc + 1;
            if (md == 3 && m_len < 2) m_len = 2;
         end
         m0.push_back(d0);
         m1.push_back(d1);
         if (m0.size() == m_len) begin
            exp_w = 1'b1;
            exp_t = 1'b0;
            case (m_mode)
               0: exp_d = pack2(pick(m0, 0), pick(m1, 0));
               1: exp_d = pack2(pick(m0, 1), pick(m1, 1));
               default: exp_d = pack2(pick(m0, 2), pick(m1, 2));
            endcase
            if (m_mode == 3) begin
               nxt_v = 1'b1;
               nxt_d = pack2(pick(m0, 1), pick(m1, 1));
            end
            m0.delete();
            m1.delete();
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input int d0,
                       input int d1, input int presc, input int md);
      rst       = r;
      in_valid  = v;
      in_data   = pack2(d0, d1);
      prescaler = presc[15:0];
      mode      = md[1:0];
      @(posedge clk);
      model(r, v, d0, d1, presc, md);
      #1;
      chk("w_clk", {31'd0, w_clk}, {31'd0, exp_w});
      if (exp_w) begin
         chk("out_data", {8'd0, out_data}, {8'd0, exp_d});
         chk("out_tag", {31'd0, out_tag}, {31'd0, exp_t});
      end
      if (r) begin
         chk("rst_data", {8'd0, out_data}, 32'd0);
         chk("rst_tag", {31'd0, out_tag}, 32'd0);
      end
      if (w_clk) obs.push_back({out_tag, out_data});
   endtask

   task automatic chk_obs(input string tag, input int i,
                          input logic [24:0] e);
      logic [24:0] o = (i < obs.size()) ? obs[i] : 25'h1ffffff;
      chk(tag, {7'd0, o}, {7'd0, e});
   endtask

   initial begin
      int v50[4];
      int sv[4];
      v50[0] = 100; v50[1] = 50; v50[2] = 200; v50[3] = 300;

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // SAMPLE pass-through
      obs.delete();
      for (int i = 0; i < 8; i++) step(0, 1, i, 0, 0, 0);
      chk("pass_cnt", obs.size(), 8);
      for (int i = 0; i < 8; i++) chk_obs("pass_val", i, 25'(i));

      // SAMPLE, window of 4
      obs.delete();
      for (int i = 1; i <= 8; i++) step(0, 1, 10 * i, 0, 3, 0);
      chk("s4_cnt", obs.size(), 2);
      chk_obs("s4_a", 0, 25'd40);
      chk_obs("s4_b", 1, 25'd80);

      // MAX and MIN over 5
      sv[0] = 5; sv[1] = 900; sv[2] = 3; sv[3] = 7;
      for (int md = 1; md <= 2; md++) begin
         obs.delete();
         for (int i = 0; i < 4; i++)
            step(0, 1, sv[i], (i == 0) ? 12'hfff : 0, 4, md);
         step(0, 1, 1, 0, 4, md);
         chk("pk_cnt", obs.size(), 1);
         chk_obs("pk_val", 0, (md == 1) ? 25'hfff384 : 25'h000001);
      end

      // MINMAX continuous, then with gaps
      for (int g = 0; g < 2; g++) begin
         obs.delete();
         for (int i = 0; i < 4; i++) begin
            step(0, 1, v50[i], 0, 0, 3);
            if (g == 1) step(0, 0, 0, 0, 0, 3);
         end
         step(0, 0, 0, 0, 0, 0);
         chk("mm_cnt", obs.size(), 4);
         chk_obs("mm_0", 0, {1'b0, 24'd50});
         chk_obs("mm_1", 1, {1'b1, 24'd100});
         chk_obs("mm_2", 2, {1'b0, 24'd200});
         chk_obs("mm_3", 3, {1'b1, 24'd300});
      end

      // config change mid-window
      obs.delete();
      step(0, 1, 7, 0, 3, 0);
      step(0, 1, 2, 0, 3, 0);
      step(0, 1, 8, 0, 1, 1);
      step(0, 1, 4, 0, 1, 1);
      step(0, 1, 9, 0, 1, 1);
      step(0, 1, 5, 0, 1, 1);
      chk("cfg_cnt", obs.size(), 2);
      chk_obs("cfg_a", 0, 25'd4);
      chk_obs("cfg_b", 1, 25'd9);

      // reset mid-window
      obs.delete();
      step(0, 1, 33, 0, 3, 0);
      step(0, 1, 44, 0, 3, 0);
      step(1, 1, 55, 0, 3, 0);
      for (int i = 11; i <= 14; i++) step(0, 1, i, 0, 3, 0);
      chk("rst_cnt", obs.size(), 1);
      chk_obs("rst_val", 0, 25'd14);

      // longest window: counter reaches all-ones
      obs.delete();
      for (int i = 0; i < 65536; i++) step(0, 1, i, 1, 16'hffff, 0);
      chk("max_cnt", obs.size(), 1);
      chk_obs("max_val", 0, 25'h001fff);

      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         step(0, ($urandom_range(0, 9) < 7), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(1, 5),
              $urandom_range(0, 3));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
